// File: rtl/tdm_demux_4ch_pkg.sv
// Shared constants for the 4-channel TDM demultiplexer and its slot counter.
package tdm_demux_4ch_pkg;

  localparam int SLOT_CNT_W = 2;
  localparam int NUM_CH     = 4;

  localparam logic [SLOT_CNT_W-1:0] SLOT0 = 2'd0;
  localparam logic [SLOT_CNT_W-1:0] SLOT1 = 2'd1;
  localparam logic [SLOT_CNT_W-1:0] SLOT2 = 2'd2;
  localparam logic [SLOT_CNT_W-1:0] SLOT3 = 2'd3;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position tracker: counts valid beats within a frame, realigns on frame_sync
// and decodes frame completion / mid-frame sync events for the data path.
module tdm_slot_counter
  import tdm_demux_4ch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  din_valid,
  input  logic                  frame_sync,
  output logic [SLOT_CNT_W-1:0] slot,
  output logic                  accept,
  output logic                  slot3,
  output logic                  mid_sync,
  output logic                  locked
);

  logic [SLOT_CNT_W-1:0] cnt_reg, cnt_next;
  logic                  locked_reg, locked_next;
  logic                  sync_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= SLOT0;
      locked_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      locked_reg <= locked_next;
    end
  end

  // A sync beat is always slot 0, whatever the counter expected.
  always_comb begin
    sync_beat   = din_valid & frame_sync;
    slot        = frame_sync ? SLOT0 : cnt_reg;
    accept      = din_valid & (frame_sync | locked_reg);
    slot3       = accept & ~frame_sync & (cnt_reg == SLOT3);
    mid_sync    = sync_beat & (cnt_reg != SLOT0);
    cnt_next    = cnt_reg;
    locked_next = locked_reg;
    if (accept)
      cnt_next = slot + SLOT1;
    if (sync_beat)
      locked_next = 1'b1;
  end

  assign locked = locked_reg;

endmodule

// File: rtl/tdm_demux_4ch.sv
// 4-channel TDM demultiplexer: collects slots 0..2 in shadow registers and
// publishes all four channels together when slot 3 of a framed sequence lands.
module tdm_demux_4ch
  import tdm_demux_4ch_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_sync,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err
);

  logic [SLOT_CNT_W-1:0] slot;
  logic                  accept;
  logic                  slot3;
  logic                  mid_sync;

  logic [W-1:0] sh_reg  [NUM_CH-1];
  logic [W-1:0] out_reg [NUM_CH];
  logic         frame_valid_reg;
  logic         sync_err_reg;

  tdm_slot_counter u_slot_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .slot       (slot),
    .accept     (accept),
    .slot3      (slot3),
    .mid_sync   (mid_sync),
    .locked     (locked)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH - 1; gi++) begin : g_shadow
      localparam logic [SLOT_CNT_W-1:0] IDX = SLOT_CNT_W'(gi);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          sh_reg[gi] <= '0;
        else if (accept && slot == IDX)
          sh_reg[gi] <= din;
      end
    end

    // Slot 3 goes straight from din so all channels update on the same edge.
    for (gi = 0; gi < NUM_CH; gi++) begin : g_out
      if (gi == NUM_CH - 1) begin : g_last
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            out_reg[gi] <= '0;
          else if (slot3)
            out_reg[gi] <= din;
        end
      end else begin : g_shadowed
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            out_reg[gi] <= '0;
          else if (slot3)
            out_reg[gi] <= sh_reg[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
    end else begin
      frame_valid_reg <= slot3;
      sync_err_reg    <= mid_sync;
    end
  end

  assign out0        = out_reg[0];
  assign out1        = out_reg[1];
  assign out2        = out_reg[2];
  assign out3        = out_reg[3];
  assign frame_valid = frame_valid_reg;
  assign sync_err    = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Scoreboard bench for tdm_demux_4ch: expected frames are queued as slot-3 beats
// are driven and checked against the outputs whenever frame_valid pulses.
module tb_tdm_demux_4ch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] out0, out1, out2, out3;
  logic       frame_valid, locked, sync_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fv_count = 0;
  int se_count = 0;
  int fv_cyc[$];
  logic [31:0] exp_q[$];
  logic prev_fv = 1'b0;

  tdm_demux_4ch #(.W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops one expected frame per frame_valid pulse.
  always @(negedge clk) begin
    if (sync_err === 1'b1) se_count++;
    if (frame_valid === 1'b1) begin
      fv_count++;
      fv_cyc.push_back(cyc);
      total++;
      if (prev_fv) begin
        bad++;
        $display("FAIL fv_width: frame_valid high 2 cycles in a row at cyc %0d, required 1", cyc);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_frame: got %h%h%h%h, required no frame", out0, out1, out2, out3);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({out0, out1, out2, out3} !== e) begin
          bad++;
          $display("FAIL frame_data: got %h%h%h%h, required %h", out0, out1, out2, out3, e);
        end else
          $display("frame ok: %h%h%h%h at cyc %0d", out0, out1, out2, out3, cyc);
      end
    end
    prev_fv = frame_valid;
  end

  task automatic beat(input logic [7:0] d, input logic s);
    @(negedge clk);
    din = d; din_valid = 1'b1; frame_sync = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din = 8'hEE; din_valid = 1'b0; frame_sync = 1'b1;
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({out0, out1, out2, out3} !== 32'h0 || frame_valid !== 1'b0 || locked !== 1'b0 || sync_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %h%h%h%h fv=%b lk=%b se=%b, required all 0",
               out0, out1, out2, out3, frame_valid, locked, sync_err);
    end
    @(negedge clk); rst_n = 1'b1;
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    idle(3);
    total++;
    if ({out0, out1, out2, out3} !== 32'h0 || locked !== 1'b0 || fv_count != 0) begin
      bad++;
      $display("FAIL reset_nosync: got %h%h%h%h lk=%b frames=%0d, required 0 / 0 / 0",
               out0, out1, out2, out3, locked, fv_count);
    end
  endtask

  task automatic test_basic_frame();
    int fv0;
    fv0 = fv_count;
    exp_q.push_back(32'hA1B2C3D4);
    beat(8'hA1, 1'b1);
    beat(8'hB2, 1'b0);
    beat(8'hC3, 1'b0);
    beat(8'hD4, 1'b0);
    idle(1);
    total++;
    if (frame_valid !== 1'b1 || {out0, out1, out2, out3} !== 32'hA1B2C3D4) begin
      bad++;
      $display("FAIL basic_latency: got fv=%b out=%h%h%h%h, required fv=1 out=a1b2c3d4",
               frame_valid, out0, out1, out2, out3);
    end
    idle(2);
    total++;
    if (fv_count - fv0 != 1 || locked !== 1'b1) begin
      bad++;
      $display("FAIL basic_frame: got frames=%0d locked=%b, required 1 / 1", fv_count - fv0, locked);
    end
  endtask

  task automatic test_gaps();
    int fv0;
    fv0 = fv_count;
    exp_q.push_back(32'h01020304);
    beat(8'h01, 1'b1); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
    exp_q.push_back(32'h10203040);
    beat(8'h10, 1'b1); beat(8'h20, 1'b0);
    idle(3);
    total++;
    if ({out0, out1, out2, out3} !== 32'h01020304) begin
      bad++;
      $display("FAIL gap_hold: got %h%h%h%h, required 01020304", out0, out1, out2, out3);
    end
    beat(8'h30, 1'b0); beat(8'h40, 1'b0);
    idle(3);
    total++;
    if (fv_count - fv0 != 2 || {out0, out1, out2, out3} !== 32'h10203040) begin
      bad++;
      $display("FAIL gap_frames: got frames=%0d out=%h%h%h%h, required 2 / 10203040",
               fv_count - fv0, out0, out1, out2, out3);
    end
  endtask

  task automatic test_mid_sync();
    int fv0, se0;
    fv0 = fv_count;
    se0 = se_count;
    beat(8'h55, 1'b1); beat(8'h66, 1'b0);
    exp_q.push_back(32'h778899AA);
    beat(8'h77, 1'b1);
    beat(8'h88, 1'b0);
    total++;
    if (sync_err !== 1'b1) begin
      bad++;
      $display("FAIL sync_err_pulse: got %b, required 1", sync_err);
    end
    beat(8'h99, 1'b0);
    total++;
    if (sync_err !== 1'b0) begin
      bad++;
      $display("FAIL sync_err_width: got %b, required 0", sync_err);
    end
    beat(8'hAA, 1'b0);
    idle(3);
    total++;
    if (fv_count - fv0 != 1 || se_count - se0 != 1 || {out0, out1, out2, out3} !== 32'h778899AA) begin
      bad++;
      $display("FAIL mid_sync: got frames=%0d errs=%0d out=%h%h%h%h, required 1 / 1 / 778899aa",
               fv_count - fv0, se_count - se0, out0, out1, out2, out3);
    end
  endtask

  task automatic test_reset_mid_frame();
    int fv0;
    fv0 = fv_count;
    beat(8'h01, 1'b1); beat(8'h02, 1'b0);
    idle(1);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    beat(8'h03, 1'b0); beat(8'h04, 1'b0);
    idle(3);
    total++;
    if ({out0, out1, out2, out3} !== 32'h0 || locked !== 1'b0 || fv_count != fv0) begin
      bad++;
      $display("FAIL reset_mid_frame: got %h%h%h%h lk=%b frames=%0d, required 0 / 0 / 0",
               out0, out1, out2, out3, locked, fv_count - fv0);
    end
  endtask

  task automatic test_back_to_back();
    int c0, se0;
    logic [7:0] d;
    se0 = se_count;
    fv_cyc.delete();
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back({8'(8'h40 + f * 4), 8'(8'h41 + f * 4), 8'(8'h42 + f * 4), 8'(8'h43 + f * 4)});
      for (int s = 0; s < 4; s++) begin
        d = 8'(8'h40 + f * 4 + s);
        beat(d, s == 0 && f == 0);
        if (f == 0 && s == 0) c0 = cyc;
      end
    end
    idle(3);
    total++;
    if (fv_cyc.size() != 3) begin
      bad++;
      $display("FAIL stream_count: got %0d frame_valid pulses, required 3", fv_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (fv_cyc[i] - c0 != 4 * (i + 1)) begin
          bad++;
          $display("FAIL stream_timing: pulse %0d at +%0d cycles, required +%0d", i, fv_cyc[i] - c0, 4 * (i + 1));
        end
      end
    end
    total++;
    if (se_count != se0) begin
      bad++;
      $display("FAIL stream_sync_err: got %0d pulses, required 0", se_count - se0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gaps();
    test_mid_sync();
    test_reset_mid_frame();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d expected frames never produced, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
